hazard_stall_controller: RTL and testbench



---
 rtl/hazard_stall_controller.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage core: warm-up gating, load-use stalls,
// taken-branch flushes, EX-stage forwarding selects and saturating event counters.
module hazard_stall_controller #(
    parameter int REG_ADDR_W    = 3,
    parameter int WARMUP_CYCLES = 3,
    parameter int STALL_CYCLES  = 1,
    parameter int FLUSH_CYCLES  = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    input  logic                  i_ifid_rs_used,
    input  logic                  i_ifid_rt_used,
    input  logic [REG_ADDR_W-1:0] i_idex_rd,
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rs,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd,
    input  logic                  i_exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd,
    input  logic                  i_memwb_reg_write,
    input  logic                  i_branch_taken,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_idex_bubble,
    output logic                  o_ifid_flush,
    output logic                  o_fwd_enable,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_warm_cnt;
    logic [2:0]       r_down_cnt;
    logic             r_fwd_enable;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_load_use;
    logic       w_do_stall;
    logic       w_do_flush;
    logic       w_fwd_gate;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_load_use = i_idex_mem_read &
                        ((i_ifid_rs_used & (i_idex_rd == i_ifid_rs)) |
                         (i_ifid_rt_used & (i_idex_rd == i_ifid_rt)));

    // A taken branch outranks any stall; a branch seen inside FLUSH changes nothing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_do_stall = 1'b0;
        w_do_flush = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN, ST_STALL: begin
                    if (i_branch_taken)
                        w_do_flush = 1'b1;
                    else if (r_state == ST_STALL || w_load_use)
                        w_do_stall = 1'b1;
                end
                ST_FLUSH: w_do_flush = 1'b1;
                default:  ;
            endcase
        end
    end

    assign o_pc_write    = ~w_do_stall;
    assign o_ifid_write  = ~w_do_stall;
    assign o_idex_bubble = w_do_stall | w_do_flush;
    assign o_ifid_flush  = w_do_flush;

    assign w_fwd_gate = r_fwd_enable & ~reset;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (w_fwd_gate) begin
            if (i_exmem_reg_write && i_exmem_rd == i_idex_rs)      w_fwd_a = 2'b10;
            else if (i_memwb_reg_write && i_memwb_rd == i_idex_rs) w_fwd_a = 2'b01;
            if (i_exmem_reg_write && i_exmem_rd == i_idex_rt)      w_fwd_b = 2'b10;
            else if (i_memwb_reg_write && i_memwb_rd == i_idex_rt) w_fwd_b = 2'b01;
        end
    end

    assign o_fwd_a      = w_fwd_a;
    assign o_fwd_b      = w_fwd_b;
    assign o_fwd_enable = r_fwd_enable;
    assign o_stall_cnt  = r_stall_cnt;
    assign o_flush_cnt  = r_flush_cnt;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state      <= ST_WARMUP;
            r_warm_cnt   <= '0;
            r_down_cnt   <= '0;
            r_fwd_enable <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_do_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_do_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);

            case (r_state)
                ST_WARMUP: begin
                    if (r_warm_cnt == 4'(WARMUP_CYCLES - 1)) begin
                        r_state      <= ST_RUN;
                        r_fwd_enable <= 1'b1;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 4'd1;
                    end
                end
                ST_RUN, ST_STALL: begin
                    if (i_branch_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            r_state    <= ST_FLUSH;
                            r_down_cnt <= 3'(FLUSH_CYCLES - 1);
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (r_state == ST_STALL) begin
                        if (r_down_cnt == 3'd1) r_state <= ST_RUN;
                        else                    r_down_cnt <= r_down_cnt - 3'd1;
                    end else if (w_load_use && STALL_CYCLES > 1) begin
                        r_state    <= ST_STALL;
                        r_down_cnt <= 3'(STALL_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (r_down_cnt == 3'd1) r_state <= ST_RUN;
                    else                    r_down_cnt <= r_down_cnt - 3'd1;
                end
                default: r_state <= ST_WARMUP;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (default and long-stall/narrow-counter)
// share stimulus; a cycle model plus a hand-derived vector table supply expected values.
module tb_hazard_stall_controller;

    typedef struct packed {
        logic       rst;
        logic [2:0] ifid_rs;
        logic [2:0] ifid_rt;
        logic       rs_used;
        logic       rt_used;
        logic [2:0] idex_rd;
        logic       mem_read;
        logic [2:0] idex_rs;
        logic [2:0] idex_rt;
        logic [2:0] exmem_rd;
        logic       exmem_w;
        logic [2:0] memwb_rd;
        logic       memwb_w;
        logic       br;
    } in_t;

    // ctl packs {pc_write, ifid_write, bubble, flush, fwd_enable, fwd_a, fwd_b}
    typedef struct packed {
        in_t         in;
        logic [8:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic clk;
    logic reset;
    logic [2:0] ifid_rs, ifid_rt, idex_rd, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic ifid_rs_used, ifid_rt_used, idex_mem_read, exmem_reg_write, memwb_reg_write, branch_taken;

    logic d0_pc, d0_iw, d0_bub, d0_fl, d0_en;
    logic [1:0] d0_fa, d0_fb;
    logic [15:0] d0_sc, d0_fc;
    logic d1_pc, d1_iw, d1_bub, d1_fl, d1_en;
    logic [1:0] d1_fa, d1_fb;
    logic [3:0] d1_sc, d1_fc;

    hazard_stall_controller dut0 (
        .clk(clk), .reset(reset),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
        .i_ifid_rs_used(ifid_rs_used), .i_ifid_rt_used(ifid_rt_used),
        .i_idex_rd(idex_rd), .i_idex_mem_read(idex_mem_read),
        .i_idex_rs(idex_rs), .i_idex_rt(idex_rt),
        .i_exmem_rd(exmem_rd), .i_exmem_reg_write(exmem_reg_write),
        .i_memwb_rd(memwb_rd), .i_memwb_reg_write(memwb_reg_write),
        .i_branch_taken(branch_taken),
        .o_pc_write(d0_pc), .o_ifid_write(d0_iw), .o_idex_bubble(d0_bub),
        .o_ifid_flush(d0_fl), .o_fwd_enable(d0_en), .o_fwd_a(d0_fa), .o_fwd_b(d0_fb),
        .o_stall_cnt(d0_sc), .o_flush_cnt(d0_fc)
    );

    hazard_stall_controller #(
        .REG_ADDR_W(3), .WARMUP_CYCLES(3), .STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset(reset),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
        .i_ifid_rs_used(ifid_rs_used), .i_ifid_rt_used(ifid_rt_used),
        .i_idex_rd(idex_rd), .i_idex_mem_read(idex_mem_read),
        .i_idex_rs(idex_rs), .i_idex_rt(idex_rt),
        .i_exmem_rd(exmem_rd), .i_exmem_reg_write(exmem_reg_write),
        .i_memwb_rd(memwb_rd), .i_memwb_reg_write(memwb_reg_write),
        .i_branch_taken(branch_taken),
        .o_pc_write(d1_pc), .o_ifid_write(d1_iw), .o_idex_bubble(d1_bub),
        .o_ifid_flush(d1_fl), .o_fwd_enable(d1_en), .o_fwd_a(d1_fa), .o_fwd_b(d1_fb),
        .o_stall_cnt(d1_sc), .o_flush_cnt(d1_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;

    // Per-instance parameters and model state (remaining freeze/flush cycles, warm-up progress)
    int p_warm[2]  = '{3, 3};
    int p_stall[2] = '{1, 3};
    int p_flush[2] = '{1, 2};
    int p_max[2]   = '{65535, 15};
    int m_warm[2], m_freeze[2], m_flushl[2], m_sc[2], m_fc[2];
    bit m_fwden[2];

    logic [8:0]  snap_ctl[2];
    logic [15:0] snap_sc[2];
    logic [15:0] snap_fc[2];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cycle, act, exp);
        end
    endtask

    function automatic bit load_use(input in_t v);
        return v.mem_read && ((v.rs_used && v.idex_rd == v.ifid_rs) ||
                              (v.rt_used && v.idex_rd == v.ifid_rt));
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [2:0] src, input in_t v);
        if (v.exmem_w && v.exmem_rd == src) return 2'b10;
        if (v.memwb_w && v.memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [8:0] model_ctl(input int k, input in_t v);
        bit stall, flush;
        logic [1:0] fa, fb;
        stall = 1'b0;
        flush = 1'b0;
        fa = 2'b00;
        fb = 2'b00;
        if (!v.rst && m_warm[k] >= p_warm[k]) begin
            if (m_flushl[k] > 0 || v.br)            flush = 1'b1;
            else if (m_freeze[k] > 0 || load_use(v)) stall = 1'b1;
        end
        if (!v.rst && m_fwden[k]) begin
            fa = fwd_ref(v.idex_rs, v);
            fb = fwd_ref(v.idex_rt, v);
        end
        return {!stall, !stall, stall | flush, flush, m_fwden[k], fa, fb};
    endfunction

    task automatic model_adv(input int k, input in_t v);
        if (v.rst) begin
            m_warm[k] = 0; m_freeze[k] = 0; m_flushl[k] = 0;
            m_sc[k] = 0; m_fc[k] = 0; m_fwden[k] = 1'b0;
        end else if (m_warm[k] < p_warm[k]) begin
            m_warm[k]++;
            if (m_warm[k] == p_warm[k]) m_fwden[k] = 1'b1;
        end else if (m_flushl[k] > 0) begin
            m_flushl[k]--;
            if (m_fc[k] < p_max[k]) m_fc[k]++;
        end else if (v.br) begin
            m_flushl[k] = p_flush[k] - 1;
            m_freeze[k] = 0;
            if (m_fc[k] < p_max[k]) m_fc[k]++;
        end else if (m_freeze[k] > 0) begin
            m_freeze[k]--;
            if (m_sc[k] < p_max[k]) m_sc[k]++;
        end else if (load_use(v)) begin
            m_freeze[k] = p_stall[k] - 1;
            if (m_sc[k] < p_max[k]) m_sc[k]++;
        end
    endtask

    task automatic drive(input in_t v);
        reset = v.rst;
        ifid_rs = v.ifid_rs; ifid_rt = v.ifid_rt;
        ifid_rs_used = v.rs_used; ifid_rt_used = v.rt_used;
        idex_rd = v.idex_rd; idex_mem_read = v.mem_read;
        idex_rs = v.idex_rs; idex_rt = v.idex_rt;
        exmem_rd = v.exmem_rd; exmem_reg_write = v.exmem_w;
        memwb_rd = v.memwb_rd; memwb_reg_write = v.memwb_w;
        branch_taken = v.br;
    endtask

    // Apply one cycle of inputs, compare both instances against the model at the falling edge.
    task automatic step(input in_t v);
        drive(v);
        @(negedge clk);
        snap_ctl[0] = {d0_pc, d0_iw, d0_bub, d0_fl, d0_en, d0_fa, d0_fb};
        snap_ctl[1] = {d1_pc, d1_iw, d1_bub, d1_fl, d1_en, d1_fa, d1_fb};
        snap_sc[0] = d0_sc;          snap_fc[0] = d0_fc;
        snap_sc[1] = {12'd0, d1_sc}; snap_fc[1] = {12'd0, d1_fc};
        for (int k = 0; k < 2; k++) begin
            check("ctl", k, 32'(snap_ctl[k]), 32'(model_ctl(k, v)));
            check("stall_cnt", k, 32'(snap_sc[k]), m_sc[k]);
            check("flush_cnt", k, 32'(snap_fc[k]), m_fc[k]);
        end
        for (int k = 0; k < 2; k++) model_adv(k, v);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    in_t hz, hz_rst, fw5, fw6, hz_br, idle, fb, fb_lu, fb_nolu, br_only, lu_rst, rv;
    vec_t tbl[13];
    int sc_mark;

    initial begin
        idle = '0;
        hz = '0;
        hz.ifid_rs = 3'd3; hz.rs_used = 1'b1; hz.idex_rd = 3'd3; hz.mem_read = 1'b1;
        hz.idex_rs = 3'd5; hz.idex_rt = 3'd2; hz.exmem_rd = 3'd5; hz.exmem_w = 1'b1;
        hz.memwb_rd = 3'd5; hz.memwb_w = 1'b1;
        hz_rst = hz; hz_rst.rst = 1'b1;
        fw5 = hz; fw5.mem_read = 1'b0;
        fw6 = fw5; fw6.exmem_w = 1'b0;
        hz_br = hz; hz_br.br = 1'b1;
        fb = '0;
        fb.exmem_rd = 3'd2; fb.exmem_w = 1'b1; fb.idex_rt = 3'd2; fb.idex_rs = 3'd5;
        fb.memwb_rd = 3'd5; fb.memwb_w = 1'b1;
        fb_lu = fb; fb_lu.mem_read = 1'b1; fb_lu.idex_rd = 3'd4; fb_lu.ifid_rt = 3'd4; fb_lu.rt_used = 1'b1;
        fb_nolu = fb; fb_nolu.mem_read = 1'b1; fb_nolu.idex_rd = 3'd4;
        fb_nolu.ifid_rs = 3'd4; fb_nolu.ifid_rt = 3'd4;
        br_only = '0; br_only.br = 1'b1;
        lu_rst = fb_lu; lu_rst.rst = 1'b1;

        // Expected values for the default instance (warm-up 3, stall 1, flush 1)
        tbl[0]  = '{in: hz_rst,  ctl: 9'b1_1_0_0_0_00_00, sc: 16'd0, fc: 16'd0};
        tbl[1]  = '{in: hz,      ctl: 9'b1_1_0_0_0_00_00, sc: 16'd0, fc: 16'd0};
        tbl[2]  = '{in: hz,      ctl: 9'b1_1_0_0_0_00_00, sc: 16'd0, fc: 16'd0};
        tbl[3]  = '{in: hz,      ctl: 9'b1_1_0_0_0_00_00, sc: 16'd0, fc: 16'd0};
        tbl[4]  = '{in: hz,      ctl: 9'b0_0_1_0_1_10_00, sc: 16'd0, fc: 16'd0};
        tbl[5]  = '{in: fw5,     ctl: 9'b1_1_0_0_1_10_00, sc: 16'd1, fc: 16'd0};
        tbl[6]  = '{in: fw6,     ctl: 9'b1_1_0_0_1_01_00, sc: 16'd1, fc: 16'd0};
        tbl[7]  = '{in: hz_br,   ctl: 9'b1_1_1_1_1_10_00, sc: 16'd1, fc: 16'd0};
        tbl[8]  = '{in: idle,    ctl: 9'b1_1_0_0_1_00_00, sc: 16'd1, fc: 16'd1};
        tbl[9]  = '{in: fb,      ctl: 9'b1_1_0_0_1_01_10, sc: 16'd1, fc: 16'd1};
        tbl[10] = '{in: fb_lu,   ctl: 9'b0_0_1_0_1_01_10, sc: 16'd1, fc: 16'd1};
        tbl[11] = '{in: fb_nolu, ctl: 9'b1_1_0_0_1_01_10, sc: 16'd2, fc: 16'd1};
        tbl[12] = '{in: idle,    ctl: 9'b1_1_0_0_1_00_00, sc: 16'd2, fc: 16'd1};

        // First reset edge brings the flops out of X; the table opens on the second reset cycle.
        drive(hz_rst);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_adv(k, hz_rst);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in);
            check("tbl_ctl", 0, 32'(snap_ctl[0]), 32'(tbl[i].ctl));
            check("tbl_stall_cnt", 0, 32'(snap_sc[0]), 32'(tbl[i].sc));
            check("tbl_flush_cnt", 0, 32'(snap_fc[0]), 32'(tbl[i].fc));
        end

        // Three-cycle stall aborted by a branch on its second cycle
        repeat (3) step(idle);
        sc_mark = m_sc[1];
        step(fb_lu);
        check("abort_entry_pc", 1, 32'(snap_ctl[1][8]), 32'd0);
        step(br_only);
        check("abort_flush_pc", 1, 32'({snap_ctl[1][8], snap_ctl[1][5], snap_ctl[1][6]}), 32'b111);
        step(idle);
        check("abort_flush2", 1, 32'(snap_ctl[1][5]), 32'd1);
        step(idle);
        check("abort_run_pc", 1, 32'({snap_ctl[1][8], snap_ctl[1][5]}), 32'b10);
        check("abort_stall_cnt", 1, 32'(snap_sc[1]), 32'(sc_mark + 1));

        // Narrow counters hold at all-ones
        repeat (20) step(fb_lu);
        step(idle);
        check("stall_sat", 1, 32'(snap_sc[1]), 32'd15);
        repeat (20) step(br_only);
        step(idle);
        check("flush_sat", 1, 32'(snap_fc[1]), 32'd15);

        // Reset landing in the middle of a stall
        repeat (3) step(idle);
        step(fb_lu);
        step(lu_rst);
        check("rst_passthru", 1, 32'(snap_ctl[1][8:5]), 32'b1100);
        step(fb_lu);
        check("rst_fwd_en", 1, 32'(snap_ctl[1][4]), 32'd0);
        check("rst_stall_cnt", 1, 32'(snap_sc[1]), 32'd0);
        check("rst_flush_cnt", 1, 32'(snap_fc[1]), 32'd0);
        check("rst_warm_pc", 1, 32'(snap_ctl[1][8]), 32'd1);
        repeat (4) step(fb_lu);

        // Randomized traffic over a narrow register range to provoke frequent matches
        for (int n = 0; n < 3000; n++) begin
            rv.rst      = ($urandom_range(0, 99) == 0);
            rv.ifid_rs  = 3'($urandom_range(0, 3));
            rv.ifid_rt  = 3'($urandom_range(0, 3));
            rv.rs_used  = 1'($urandom_range(0, 1));
            rv.rt_used  = 1'($urandom_range(0, 1));
            rv.idex_rd  = 3'($urandom_range(0, 3));
            rv.mem_read = 1'($urandom_range(0, 1));
            rv.idex_rs  = 3'($urandom_range(0, 3));
            rv.idex_rt  = 3'($urandom_range(0, 3));
            rv.exmem_rd = 3'($urandom_range(0, 3));
            rv.exmem_w  = 1'($urandom_range(0, 1));
            rv.memwb_rd = 3'($urandom_range(0, 3));
            rv.memwb_w  = 1'($urandom_range(0, 1));
            rv.br       = ($urandom_range(0, 6) == 0);
            step(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
